rf_port_ctrl: RTL
=================

Name: rf_port_ctrl

Overview:
Port controller in front of the 32x32 register file (2 registered read ports, 1 write port). Arbitrates the single write port between two writers (A, B) with round-robin. Issues paired reads and stalls any read that would miss a same-edge write. Provides a 32-cycle hardware clear sequence that zeroes every register without a global reset.

Parameters:
ZERO_REG, 1, when 1 writes to address 0 are accepted but not committed (rf_r3_wr held 0)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wa_valid  in  1  writer A request
wa_ready  out  1  writer A accepted (transfer on valid&ready at posedge)
wa_addr  in  AW  writer A address
wa_data  in  DW  writer A data
wb_valid  in  1  writer B request
wb_ready  out  1  writer B accepted
wb_addr  in  AW  writer B address
wb_data  in  DW  writer B data
rd_valid  in  1  read request
rd_ready  out  1  read accepted
rd_addr1  in  AW  read address, port 1
rd_addr2  in  AW  read address, port 2
rsp_valid  out  1  read data valid (single-cycle pulse, no backpressure)
rsp_data1  out  DW  read data, port 1
rsp_data2  out  DW  read data, port 2
clr_req  in  1  start clear sequence
clr_done  out  1  one-cycle pulse when clear completes
rf_r1_addr  out  AW  to register file
rf_r2_addr  out  AW  to register file
rf_r3_addr  out  AW  to register file
rf_r3_din  out  DW  to register file
rf_r3_wr  out  1  to register file
rf_r1_dout  in  DW  from register file
rf_r2_dout  in  DW  from register file

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=RUN, clr_cnt=0, prio=0 (A favoured), rsp_valid=0, clr_done=0. All readies are combinational and evaluate to their RUN values after reset.
- FSM states:
  - RUN: normal operation.
  - CLEAR: zeroing sweep.
- RUN -> CLEAR: on any posedge with clr_req=1. While clr_req=1 in RUN, wa_ready=wb_ready=rd_ready=0 in that same cycle.
- CLEAR behaviour:
  - rf_r3_wr=1, rf_r3_addr=clr_cnt, rf_r3_din=0; all readies 0.
  - clr_cnt increments each cycle.
  - When clr_cnt==31: clr_cnt<=0, state<=RUN, clr_done<=1 for exactly one cycle.
  - clr_req is ignored while in CLEAR. Total duration is 32 cycles.
- Write arbitration (RUN, clr_req=0):
  - Only one writer valid: that writer is granted.
  - Both valid: the writer selected by prio is granted (0=A, 1=B).
  - grant drives rf_r3_addr/rf_r3_din combinationally.
  - rf_r3_wr = granted valid & !(ZERO_REG & addr==0).
  - The write commits at the same posedge as the handshake (zero added latency).
  - prio update: A transfer sets prio<=1; B transfer sets prio<=0. No transfer leaves prio unchanged.
  - The non-granted writer's ready is 0.
- Read path:
  - rf_r1_addr=rd_addr1, rf_r2_addr=rd_addr2, always driven.
  - Hazard: rd_ready=0 if rf_r3_wr=1 in RUN and rf_r3_addr equals rd_addr1 or rd_addr2. Otherwise rd_ready=1 (RUN, clr_req=0).
  - Accepted read: rsp_valid<=1 at the acceptance edge, so it is high in the next cycle.
  - rsp_data1/2 = rf_r1_dout/rf_r2_dout passthrough. Data is valid only while rsp_valid=1.
  - Total read latency: 1 cycle from acceptance.
  - Back-to-back reads give rsp_valid high every cycle.
  - Write and read to different addresses in the same cycle: both accepted.
  - A read accepted after a write commits returns the new value.
- Ordering: a response in flight when clear starts is still delivered, carrying pre-clear data.
- Address-0 writes with ZERO_REG=1: they do not cause hazard stalls.
- Reset mid-CLEAR: returns to RUN with clr_cnt=0; clr_done is not pulsed.

Test Plan:
- Arbitration: wa_valid=wb_valid=1 for 4 cycles (A addr 1..4, B addr 11..14) -> grants alternate A,B,A,B starting with A. Registers 1,11,2,12 written in that order.
- Read after write: write 0xDEADBEEF to r5 at edge N; read r5,r6 at edge N+1 -> rsp_valid at N+2 with rsp_data1=0xDEADBEEF.
- Hazard: wa writes r7=0x1234 while a read of (r7,r3) is requested in the same cycle -> rd_ready=0 that cycle; read accepted next cycle; rsp_data1=0x1234.
- ZERO_REG=1: write r0=0xFFFFFFFF -> wa_ready=1, rf_r3_wr=0; a subsequent read of r0 returns 0.
- Clear: fill r0..r31 with nonzero values, pulse clr_req -> readies 0 for 33 cycles (request cycle plus 32 clear cycles); clr_done pulse one cycle after the r31 write; all reads return 0 afterwards.
- Reset mid-clear: assert rst_n=0 at clr_cnt=10 -> state RUN, no clr_done, rsp_valid=0, prio=0 (A granted first on contention).

Source files
------------

// File: rtl/rf_port_ctrl.sv
// Port controller for a 32x32 register file: round-robin arbitration of the
// single write port between writers A and B, paired reads with a same-edge
// write hazard stall, and a hardware clear sweep that zeroes every register.
module rf_port_ctrl #(
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_valid,
  output logic          wa_ready,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data1,
  output logic [DW-1:0] rsp_data2,
  input  logic          clr_req,
  output logic          clr_done,
  output logic [AW-1:0] rf_r1_addr,
  output logic [AW-1:0] rf_r2_addr,
  output logic [AW-1:0] rf_r3_addr,
  output logic [DW-1:0] rf_r3_din,
  output logic          rf_r3_wr,
  input  logic [DW-1:0] rf_r1_dout,
  input  logic [DW-1:0] rf_r2_dout
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            prio_q, prio_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            clr_done_q, clr_done_d;

  logic            in_run;
  logic            open;
  logic            gnt_a;
  logic            gnt_b;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            zero_drop;
  logic            hazard;

  // Read addresses go straight to the register file; response data is a passthrough.
  always_comb begin
    rf_r1_addr = rd_addr1;
    rf_r2_addr = rd_addr2;
    rsp_data1  = rf_r1_dout;
    rsp_data2  = rf_r2_dout;
    rsp_valid  = rsp_valid_q;
    clr_done   = clr_done_q;
  end

  // Arbitration, write-port muxing, hazard detection and handshakes.
  always_comb begin
    in_run    = (state_q == RUN);
    open      = in_run & ~clr_req;
    gnt_b     = wb_valid & (~wa_valid | prio_q);
    gnt_a     = wa_valid & ~gnt_b;
    w_addr    = gnt_b ? wb_addr : wa_addr;
    w_data    = gnt_b ? wb_data : wa_data;
    zero_drop = ZERO_REG && (w_addr == '0);

    if (state_q == CLEAR) begin
      rf_r3_addr = clr_cnt_q;
      rf_r3_din  = '0;
      rf_r3_wr   = 1'b1;
    end else begin
      rf_r3_addr = w_addr;
      rf_r3_din  = w_data;
      rf_r3_wr   = open & (gnt_a | gnt_b) & ~zero_drop;
    end

    wa_ready = open & gnt_a;
    wb_ready = open & gnt_b;
    hazard   = in_run & rf_r3_wr &
               ((rf_r3_addr == rd_addr1) | (rf_r3_addr == rd_addr2));
    rd_ready = open & ~hazard;
  end

  // Next-state logic for the FSM, clear counter, priority and pulse outputs.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    prio_d      = prio_q;
    rsp_valid_d = rd_valid & rd_ready;
    clr_done_d  = 1'b0;

    if (wa_valid & wa_ready) prio_d = 1'b1;
    if (wb_valid & wb_ready) prio_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == {AW{1'b1}}) begin
          clr_cnt_d  = '0;
          state_d    = RUN;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      clr_cnt_q   <= '0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      clr_done_q  <= clr_done_d;
    end
  end

endmodule
